// File: rtl/dft_mac_engine.sv
// Complex multiply-accumulate engine for one DFT bin: X = sum x[n]*W[n].
// Two-stage datapath (products, then round/accumulate/saturate) with valid/ready on both sides.
module dft_mac_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 16,
  parameter int unsigned FRAC   = 15,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         len,
  input  logic                     real_only,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_re,
  input  logic signed [DATA_W-1:0] x_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_re,
  output logic signed [ACC_W-1:0]  out_im,
  output logic                     ovf,
  output logic                     busy
);

  localparam int unsigned PW = DATA_W + TW_W;
  localparam int unsigned SW = PW + 2;
  localparam logic signed [SW-1:0]    RND     = SW'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] len_q, cnt;
  logic real_only_q;
  logic s1_valid;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_W-1:0] xi;
  logic start_ok, accept, last_beat, xfer;
  logic in_ready_d, busy_d, out_valid_d;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [ACC_W:0] r_re, r_im, sum_re, sum_im;
  logic sat_re, sat_im;
  logic signed [ACC_W-1:0] acc_re_nxt, acc_im_nxt;

  assign start_ok  = (state == IDLE) && start && (len != '0);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (cnt == len_q - CNT_W'(1));
  assign xfer      = out_valid && out_ready;
  assign xi        = real_only_q ? '0 : x_im;

  // State and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid) state_nxt = DONE;
      DONE:    if (xfer)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    in_ready_d  = (state_nxt == RUN);
    busy_d      = (state_nxt != IDLE);
    out_valid_d = (state_nxt == DONE);
  end

  // Stage 2: combine, round half-up (floor after bias), accumulate with one guard bit, clamp
  always_comb begin
    re_sum = SW'(p_rr) - SW'(p_ii) + RND;
    im_sum = SW'(p_ri) + SW'(p_ir) + RND;
    r_re   = (ACC_W+1)'(re_sum >>> FRAC);
    r_im   = (ACC_W+1)'(im_sum >>> FRAC);
    sum_re = {out_re[ACC_W-1], out_re} + r_re;
    sum_im = {out_im[ACC_W-1], out_im} + r_im;
    sat_re = sum_re[ACC_W] != sum_re[ACC_W-1];
    sat_im = sum_im[ACC_W] != sum_im[ACC_W-1];
    acc_re_nxt = sat_re ? (sum_re[ACC_W] ? ACC_MIN : ACC_MAX) : sum_re[ACC_W-1:0];
    acc_im_nxt = sat_im ? (sum_im[ACC_W] ? ACC_MIN : ACC_MAX) : sum_im[ACC_W-1:0];
  end

  // Datapath: run setup, stage-1 products, accumulator (which is also the result)
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      cnt         <= '0;
      real_only_q <= 1'b0;
      s1_valid    <= 1'b0;
      p_rr        <= '0;
      p_ii        <= '0;
      p_ri        <= '0;
      p_ir        <= '0;
      out_re      <= '0;
      out_im      <= '0;
      ovf         <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (start_ok) begin
        len_q       <= len;
        real_only_q <= real_only;
        cnt         <= '0;
        out_re      <= '0;
        out_im      <= '0;
        ovf         <= 1'b0;
      end
      if (accept) begin
        cnt  <= cnt + CNT_W'(1);
        p_rr <= PW'(x_re) * PW'(w_re);
        p_ii <= PW'(xi)   * PW'(w_im);
        p_ri <= PW'(x_re) * PW'(w_im);
        p_ir <= PW'(xi)   * PW'(w_re);
      end
      if (s1_valid) begin
        out_re <= acc_re_nxt;
        out_im <= acc_im_nxt;
        if (sat_re || sat_im) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dft_mac_engine.sv
// Directed + randomized bench for dft_mac_engine with a cycle-level expected-result model
// built from per-beat complex arithmetic, floor rounding and clamping.
module tb_dft_mac_engine;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TW_W   = 16;
  localparam int unsigned FRAC   = 15;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned CNT_W  = 12;
  localparam int MAXB   = 64;
  localparam int BUDGET = 4000;
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W - 1));

  logic clk = 1'b0;
  logic rst, start, real_only, in_valid, in_ready, out_valid, out_ready, ovf, busy;
  logic [CNT_W-1:0] len;
  logic signed [DATA_W-1:0] x_re, x_im;
  logic signed [TW_W-1:0] w_re, w_im;
  logic signed [ACC_W-1:0] out_re, out_im;

  int n_cmp = 0;
  int n_bad = 0;
  int bx_re[MAXB], bx_im[MAXB], bw_re[MAXB], bw_im[MAXB];
  longint exp_re[MAXB+1], exp_im[MAXB+1];
  bit exp_ovf[MAXB+1];

  always #5 clk = ~clk;

  dft_mac_engine #(
    .DATA_W(DATA_W), .TW_W(TW_W), .FRAC(FRAC), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .real_only(real_only),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic longint floor_div(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  // Expected accumulator/ovf after each number of completed beats
  task automatic build_model(input int n, input bit ro);
    longint d, xi, re, im, a_re, a_im, s_re, s_im;
    bit o;
    d = longint'(1) << FRAC;
    a_re = 0; a_im = 0; o = 1'b0;
    exp_re[0] = 0; exp_im[0] = 0; exp_ovf[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      xi = ro ? 0 : longint'(bx_im[i]);
      re = longint'(bx_re[i]) * bw_re[i] - xi * bw_im[i];
      im = longint'(bx_re[i]) * bw_im[i] + xi * bw_re[i];
      s_re = a_re + floor_div(re + d / 2, d);
      s_im = a_im + floor_div(im + d / 2, d);
      a_re = clamp(s_re);
      a_im = clamp(s_im);
      if (a_re != s_re || a_im != s_im) o = 1'b1;
      exp_re[i+1] = a_re; exp_im[i+1] = a_im; exp_ovf[i+1] = o;
    end
  endtask

  task automatic fill_const(input int n, input int xr, input int xim, input int wr, input int wim);
    for (int i = 0; i < n; i++) begin
      bx_re[i] = xr; bx_im[i] = xim; bw_re[i] = wr; bw_im[i] = wim;
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      bx_re[i] = rnd16(); bx_im[i] = rnd16(); bw_re[i] = rnd16(); bw_im[i] = rnd16();
    end
  endtask

  // Entered and left at a negedge; start is raised immediately (back-to-back capable)
  task automatic run(input int n, input bit ro, input int gap_pct, input int stall, input bit poke);
    int idx, h1, h2, post, cyc;
    bit go;
    build_model(n, ro);
    start = 1'b1; len = CNT_W'(n); real_only = ro;
    @(negedge clk);
    start = 1'b0; real_only = ~ro; len = CNT_W'($urandom_range(4095));
    check("busy_after_start", busy, 1);
    idx = 0; h1 = 0; h2 = 0; post = 0; cyc = 0;
    while (1) begin
      if (idx == n) post++;
      check("acc_re", out_re, exp_re[h2]);
      check("acc_im", out_im, exp_im[h2]);
      check("ovf_run", ovf, exp_ovf[h2]);
      check("in_ready", in_ready, idx < n);
      check("out_valid_timing", out_valid, post >= 3);
      if (post >= 3 || cyc >= BUDGET) break;
      go = ($urandom_range(99) >= gap_pct);
      in_valid = go;
      if (idx < n) begin
        x_re = DATA_W'(bx_re[idx]); x_im = DATA_W'(bx_im[idx]);
        w_re = TW_W'(bw_re[idx]);   w_im = TW_W'(bw_im[idx]);
      end else begin
        x_re = DATA_W'(rnd16()); x_im = DATA_W'(rnd16());
        w_re = TW_W'(rnd16());   w_im = TW_W'(rnd16());
      end
      if (poke) begin
        start = 1'($urandom_range(1)); len = CNT_W'($urandom_range(1, 4095));
      end
      if (go && idx < n) idx++;
      h2 = h1; h1 = idx;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= BUDGET) check("run_timeout", out_valid, 1);
    in_valid = 1'b0; start = 1'b0;
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      if (poke) start = 1'b1;
      check("stall_valid", out_valid, 1);
      check("stall_re", out_re, exp_re[n]);
      check("stall_im", out_im, exp_im[n]);
      check("stall_ovf", ovf, exp_ovf[n]);
      check("stall_busy", busy, 1);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    check("final_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_xfer_valid", out_valid, 0);
    check("post_xfer_busy", busy, 0);
    check("post_xfer_re", out_re, exp_re[n]);
    check("post_xfer_im", out_im, exp_im[n]);
    check("post_xfer_ovf", ovf, exp_ovf[n]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; real_only = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_re = '0; x_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    fill_const(4, 16384, 0, 32767, 0);
    run(4, 1'b0, 0, 0, 1'b0);
    check("t1_re", out_re, 65536);
    check("t1_im", out_im, 0);
    check("t1_ovf", ovf, 0);

    fill_const(1, 1000, 2000, 0, 32767);
    run(1, 1'b0, 0, 0, 1'b0);
    check("cplx_re", out_re, -2000);
    check("cplx_im", out_im, 1000);

    run(1, 1'b1, 0, 0, 1'b0);
    check("realonly_re", out_re, 0);
    check("realonly_im", out_im, 1000);

    fill_const(40, 32767, 0, 32767, 0);
    run(40, 1'b0, 0, 0, 1'b0);
    check("sat_re", out_re, 524287);
    check("sat_ovf", ovf, 1);

    fill_const(1, 0, 0, 0, 0);
    run(1, 1'b0, 0, 0, 1'b0);
    check("zero_re", out_re, 0);
    check("zero_ovf", ovf, 0);

    fill_rand(12);
    run(12, 1'b0, 40, 10, 1'b1);
    run(12, 1'b0, 0, 0, 1'b0);

    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    @(negedge clk);
    check("len0_busy_later", busy, 0);

    fill_const(4, 1000, 2000, 0, 32767);
    start = 1'b1; len = CNT_W'(4); real_only = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    x_re = DATA_W'(1000); x_im = DATA_W'(2000); w_re = '0; w_im = TW_W'(32767);
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_re", out_re, 0);
    check("midrst_im", out_im, 0);
    rst = 1'b0;
    @(negedge clk);
    run(1, 1'b0, 0, 0, 1'b0);
    check("after_rst_re", out_re, -2000);
    check("after_rst_im", out_im, 1000);

    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(1, 24));
      fill_rand(n);
      run(n, 1'($urandom_range(1)), 30, int'($urandom_range(3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dft_mac_engine.md
Name: dft_mac_engine

Overview:
- Parametrised complex multiply-accumulate engine for one DFT bin: X = sum over n of x[n]*W[n], with x a complex sample and W a complex twiddle.
- Successor to the single-lane real MUL_UNIT / Rounding_unit / Accumulation_unit chain. Adds a full complex product, configurable widths, a real-only input mode, a run length counter, saturation with a sticky overflow flag, and valid/ready handshakes on both input and output.
- Sits between the sample cache / twiddle source and the AXI write-back path.

Parameters:
- DATA_W, 16, sample component width (signed, two's complement)
- TW_W, 16, twiddle component width (signed, Q1.FRAC)
- FRAC, 15, twiddle fractional bits; the product is right-shifted by FRAC
- ACC_W, 20, accumulator / result component width (signed); ACC_W >= DATA_W+1
- CNT_W, 12, width of the run length

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to begin a run
- len  in  CNT_W  number of beats in the run; sampled when start is accepted
- real_only  in  1  when 1, x_im is treated as 0; sampled when start is accepted
- in_valid  in  1  sample/twiddle beat valid
- in_ready  out  1  engine accepts a beat
- x_re, x_im  in  DATA_W each  sample
- w_re, w_im  in  TW_W each  twiddle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_re, out_im  out  ACC_W each  accumulated result
- ovf  out  1  sticky saturation flag for the current or last run
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-run):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, busy=0, ovf=0.
  - out_re=0, out_im=0.
  - Pipeline registers and beat counter are cleared.
  - Any in-flight beats are discarded.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 with len!=0: latch len and real_only, clear accumulators and ovf, go to RUN.
  - start=1 with len=0: ignored; stay in IDLE.
- RUN:
  - in_ready=1 while the accepted-beat count < len.
  - A beat is accepted when in_valid & in_ready at a clock edge.
  - Gaps in in_valid are allowed.
  - When the len-th beat is accepted, in_ready drops on the next cycle and the state goes to DRAIN.
- Stage 1 (registered at the accepting edge E0): four signed products, each DATA_W+TW_W bits wide.
  - prr = x_re*w_re
  - pii = xi*w_im
  - pri = x_re*w_im
  - pir = xi*w_re
  - xi = real_only ? 0 : x_im
- Stage 2 (registered at E1, only for a valid stage-1 beat):
  - re = prr - pii and im = pri + pir, each DATA_W+TW_W+1 bits.
  - Round half-up: r = (v + 2^(FRAC-1)) >>> FRAC (arithmetic shift, i.e. floor).
  - Sign-extend r to ACC_W+1 bits, then add to the accumulator.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value and set ovf=1.
  - If the sum is below -2^(ACC_W-1), clamp to that value and set ovf=1.
  - ovf stays at 1 until the next accepted start or rst.
- DRAIN:
  - Wait until the last beat has passed stage 2.
  - out_valid=1 is registered at E2, where E2 is the second edge after the edge that accepted the last beat.
  - State goes to DONE at the same edge.
- DONE:
  - out_re, out_im and ovf are held stable while out_valid=1.
  - Transfer completes on out_valid & out_ready at a clock edge; then out_valid goes to 0 and state goes to IDLE at that edge.
  - out_re and out_im keep their last value after the transfer until the next start.
- start asserted in RUN, DRAIN or DONE is ignored and has no effect.
- busy=0 only in IDLE.
- Minimum turnaround:
  - start may be accepted on the cycle after the output transfer.
  - Back-to-back runs need no idle cycle beyond IDLE itself.

Test Plan:
- Real run, plain accumulation:
  - Stimulus: len=4, real_only=0; 4 beats of x=(16384,0), w=(32767,0).
  - Response: each product rounds to 16384; out=(65536,0), ovf=0.
  - Timing: out_valid rises exactly 2 edges after the 4th accept.
- Complex product and rounding:
  - Stimulus: len=1, x=(1000,2000), w=(0,32767).
  - Response: out_re=-2000 (floor of -1999.44), out_im=1000, ovf=0.
- Real-only mode:
  - Stimulus: same beat as above with real_only=1.
  - Response: out=(0,1000); x_im is ignored.
- Saturation:
  - Stimulus: len=40, x=(32767,0), w=(32767,0); each product rounds to 32766.
  - Response: after the 17th beat, out_re clamps to 524287; final out_re=524287, ovf=1.
  - Next run with len=1 and zero data: out=(0,0), ovf=0.
- Handshake stress:
  - Stimulus: random in_valid gaps; out_ready held low for 10 cycles; start pulsed during RUN and DONE.
  - Response: result identical to the gap-free run; outputs stable while stalled; extra starts ignored; len=0 start leaves busy=0.
- Reset mid-run:
  - Stimulus: rst=1 after 2 of 4 beats.
  - Response: next cycle IDLE with busy=0, in_ready=0, out_valid=0, out=(0,0).
  - A fresh len=1 run then yields the correct single-product result.
